// File: rtl/crossbar_arbiter_unit.sv
// Per-slave packet arbiters for a stream crossbar: each output picks a master
// round-robin and holds it until that master's last beat transfers.
module crossbar_arbiter_unit #(
   parameter int S_DATA_COUNT = 2,
   parameter int M_DATA_COUNT = 3,
   parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
   parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
   input  logic                                       clk_i,
   input  logic                                       rst_n_i,
   input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
   input  logic [S_DATA_COUNT-1:0]                    s_last_i,
   input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
   input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
   output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  grant_o,
   output logic [M_DATA_COUNT-1:0]                    busy_o
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   function automatic logic [T_ID___WIDTH-1:0] wrap_inc(input logic [T_ID___WIDTH-1:0] x);
      return (x == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0 : x + 1'b1;
   endfunction

   for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_slave
      state_t                  state_q, state_d;
      logic [T_ID___WIDTH-1:0] lock_q, lock_d;
      logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
      logic [T_ID___WIDTH-1:0] winner, hi_win, lo_win, grant;
      logic                    hi_found, lo_found;
      logic [S_DATA_COUNT-1:0] req;
      logic                    any_req, xfer;

      always_comb begin
         req = '0;
         for (int unsigned i = 0; i < S_DATA_COUNT; i++)
            req[i] = s_valid_i[i] && (s_dest_i[i] == T_DEST_WIDTH'(j));
      end

      // Rotating scan: lowest requester at or above ptr, else lowest below it.
      always_comb begin
         hi_found = 1'b0;
         lo_found = 1'b0;
         hi_win   = '0;
         lo_win   = '0;
         for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
            if (req[i]) begin
               if (T_ID___WIDTH'(i) >= ptr_q) begin
                  if (!hi_found) begin
                     hi_win   = T_ID___WIDTH'(i);
                     hi_found = 1'b1;
                  end
               end else if (!lo_found) begin
                  lo_win   = T_ID___WIDTH'(i);
                  lo_found = 1'b1;
               end
            end
         end
         winner = hi_found ? hi_win : lo_win;
      end

      assign any_req = |req;
      assign grant   = (state_q == LOCKED || !any_req) ? lock_q : winner;
      assign xfer    = req[grant] && m_ready_i[j];

      always_comb begin
         state_d = state_q;
         lock_d  = lock_q;
         ptr_d   = ptr_q;
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  lock_d = winner;
                  if (s_last_i[winner]) ptr_d = wrap_inc(winner);
                  else                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (xfer && s_last_i[lock_q]) begin
                  state_d = IDLE;
                  ptr_d   = wrap_inc(lock_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            state_q <= IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
         end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
         end
      end

      assign grant_o[j] = grant;
      assign busy_o[j]  = (state_q == LOCKED);
   end

endmodule
